// File: rtl/alu_pkg.sv
// Shared ALU operation encodings and the legality check used by the nibble
// sequencer and its alu4 slice.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_B   = 3'b000,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110
    } alu_ctrl_t;

    function automatic logic alu_ctrl_legal(input logic [2:0] ctrl);
        return (ctrl != 3'b001) && (ctrl != 3'b111);
    endfunction

endpackage

// File: rtl/alu4.sv
// 4-bit ALU slice with carry in/out and group propagate/generate for
// carry-lookahead use; SUB is a + ~b + c_in.
module alu4
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cIn,
    input  logic [2:0] ctrl,
    output logic [3:0] aluOut,
    output logic       cOut,
    output logic       pg,
    output logic       gg
);

    logic [3:0] b_x;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] sum;

    assign b_x = (ctrl == ALU_SUBTRACT) ? ~b : b;
    assign p   = a ^ b_x;
    assign g   = a & b_x;
    assign sum = {1'b0, a} + {1'b0, b_x} + {4'b0000, cIn};
    assign pg  = &p;
    assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    always_comb begin
        aluOut = 4'h0;
        cOut   = 1'b0;
        case (ctrl)
            ALU_PASS_B:   aluOut = b;
            ALU_ADD,
            ALU_SUBTRACT: {cOut, aluOut} = sum;
            ALU_AND:      aluOut = a & b;
            ALU_OR:       aluOut = a | b;
            ALU_XOR:      aluOut = a ^ b;
            default:      aluOut = 4'h0;
        endcase
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// WIDTH-bit ALU built from one alu4 slice stepped a nibble per cycle, LSB first.
// Define ALU_NIBBLE_SEQ_FLAGS_EN to build the carry/ovf/neg/zero flag logic.
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_neg,
    output logic             out_zero,
    output logic             out_err
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } seq_state_t;

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [3:0] nib_a, nib_b, alu_out;
    logic       alu_cout;
    logic       ctrl_ok;
    logic       accept;
    logic       last_nib;

    assign nib_a    = a_q[idx_q*4 +: 4];
    assign nib_b    = b_q[idx_q*4 +: 4];
    assign ctrl_ok  = alu_ctrl_legal(ctrl_q);
    assign accept   = (state_q == S_IDLE) && in_ready_q && in_valid;
    assign last_nib = (state_q == S_RUN) && (idx_q == IDX_W'(N - 1));

    alu4 u_alu4 (
        .a      (nib_a),
        .b      (nib_b),
        .cIn    (carry_q),
        .ctrl   (ctrl_q),
        .aluOut (alu_out),
        .cOut   (alu_cout),
        .pg     (),
        .gg     ()
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        res_d    = res_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    ctrl_d  = in_ctrl;
                    idx_d   = '0;
                    carry_d = in_ctrl[0];
                    res_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // illegal ops still take N cycles but never expose slice output
                res_d[idx_q*4 +: 4] = ctrl_ok ? alu_out : 4'h0;
                carry_d = alu_cout;
                idx_d   = idx_q + 1'b1;
                if (last_nib) begin
                    err_d   = ~ctrl_ok;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_err    = err_q;

`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
    logic cf_q, cf_d;
    logic ovf_q, ovf_d;
    logic neg_q, neg_d;
    logic zero_q, zero_d;
    logic is_arith;
    logic bx_msb;

    assign is_arith = ctrl_ok && (ctrl_q[2:1] == 2'b01);
    assign bx_msb   = ctrl_q[0] ? ~b_q[WIDTH-1] : b_q[WIDTH-1];

    always_comb begin
        cf_d   = cf_q;
        ovf_d  = ovf_q;
        neg_d  = neg_q;
        zero_d = zero_q;
        if (accept) begin
            cf_d   = 1'b0;
            ovf_d  = 1'b0;
            neg_d  = 1'b0;
            zero_d = 1'b0;
        end else if (last_nib) begin
            cf_d   = is_arith & alu_cout;
            ovf_d  = is_arith & (a_q[WIDTH-1] == bx_msb) & (res_d[WIDTH-1] != a_q[WIDTH-1]);
            neg_d  = res_d[WIDTH-1];
            zero_d = (res_d == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cf_q   <= 1'b0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            cf_q   <= cf_d;
            ovf_q  <= ovf_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
        end
    end

    assign out_carry = cf_q;
    assign out_ovf   = ovf_q;
    assign out_neg   = neg_q;
    assign out_zero  = zero_q;
`else
    assign out_carry = 1'b0;
    assign out_ovf   = 1'b0;
    assign out_neg   = 1'b0;
    assign out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq at WIDTH=16: latency, results, flags,
// backpressure and mid-operation asynchronous reset.
module tb_alu_nibble_seq;

    localparam int W = 16;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_ctrl = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_carry, out_ovf, out_neg, out_zero, out_err;

    int n_chk = 0;
    int n_bad = 0;
    int lat;

    always #5 clk = ~clk;

    alu_nibble_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_neg    (out_neg),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_ctrl  = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!out_valid && l < 20);
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] r, input logic c,
                             input logic v, input logic n, input logic z, input logic e);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, out_result, r);
        chk({tag, "_err"}, out_err, e);
        chk({tag, "_carry"}, out_carry, FL & c);
        chk({tag, "_ovf"}, out_ovf, FL & v);
        chk({tag, "_neg"}, out_neg, FL & n);
        chk({tag, "_zero"}, out_zero, FL & z);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready_after_handshake", in_ready, 1);
        chk("out_valid_after_handshake", out_valid, 0);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_err", out_err, 0);
        chk("rst_flags", {out_carry, out_ovf, out_neg, out_zero}, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        send(16'h00FF, 16'h0001, 3'b010);
        wait_result(lat);
        chk("add1_latency", lat, 5);
        check_out("add1", 16'h0100, 0, 0, 0, 0, 0);
        release_out();

        send(16'hFFFF, 16'h0001, 3'b010);
        wait_result(lat);
        check_out("add2", 16'h0000, 1, 0, 0, 1, 0);
        release_out();

        send(16'h8000, 16'h0001, 3'b011);
        wait_result(lat);
        check_out("sub", 16'h7FFF, 1, 1, 0, 0, 0);
        release_out();

        send(16'h0001, 16'h0002, 3'b011);
        wait_result(lat);
        check_out("sub_borrow", 16'hFFFF, 0, 0, 1, 0, 0);
        release_out();

        send(16'hA5A5, 16'h0FF0, 3'b100);
        wait_result(lat);
        check_out("and", 16'h05A0, 0, 0, 0, 0, 0);
        release_out();

        send(16'hFFFF, 16'hFFFF, 3'b110);
        wait_result(lat);
        check_out("xor", 16'h0000, 0, 0, 0, 1, 0);
        release_out();

        send(16'h1200, 16'h8034, 3'b101);
        wait_result(lat);
        check_out("or", 16'h9234, 0, 0, 1, 0, 0);
        release_out();

        send(16'hFFFF, 16'h5A5A, 3'b000);
        wait_result(lat);
        check_out("pass_b", 16'h5A5A, 0, 0, 0, 0, 0);
        release_out();

        send(16'h1234, 16'h4321, 3'b111);
        wait_result(lat);
        chk("illegal_latency", lat, 5);
        check_out("illegal", 16'h0000, 0, 0, 0, 1, 1);
        release_out();

        // backpressure: new request offered while the result is held
        send(16'h7FFF, 16'h0001, 3'b010);
        wait_result(lat);
        check_out("bp", 16'h8000, 0, 1, 1, 0, 0);
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        in_ctrl  = 3'b110;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid_held", out_valid, 1);
            chk("bp_result_held", out_result, 16'h8000);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_flags_held", {out_carry, out_ovf, out_neg}, {1'b0, FL, FL});
        end
        in_valid = 1'b0;
        release_out();
        repeat (6) @(negedge clk);
        chk("bp_no_latch", out_valid, 0);
        chk("bp_idle_ready", in_ready, 1);

        // asynchronous reset while the third nibble is being processed
        send(16'h1234, 16'h1111, 3'b010);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_result", out_result, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_err_flags", {out_err, out_carry, out_ovf, out_neg, out_zero}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        send(16'h1234, 16'h1111, 3'b010);
        wait_result(lat);
        chk("post_rst_latency", lat, 5);
        check_out("post_rst", 16'h2345, 0, 0, 0, 0, 0);
        release_out();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
